// File: rtl/rvx_wait_state_responder.sv
// ---------------------------------------------------------------------------
// rvx_wait_state_responder
//
// Memory-side responder for the RVX core data bus. It behaves like a slow
// memory-mapped peripheral: a small word-addressed RAM plus a "tohost"
// completion register. Every request is answered after a fixed number of
// wait states, so the core's stall handling can be exercised.
//
// Parameters:
//   BASE_ADDRESS   byte base address of the RAM window
//   DEPTH_WORDS    number of 32-bit RAM words (power of two, >= 4)
//   TOHOST_ADDRESS byte address of the completion register
//   WAIT_STATES    idle cycles between request and response (0..15)
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   address        byte address, sampled in the request cycle
//   rdata          read data, non-zero only while rresponse=1
//   rrequest       single-cycle read request pulse
//   rresponse      single-cycle read completion pulse
//   wdata          write data, sampled in the request cycle
//   wstrobe        byte enables for wdata
//   wrequest       single-cycle write request pulse
//   wresponse      single-cycle write completion pulse
//   tohost_valid   sticky flag, set by any write to TOHOST_ADDRESS
//   tohost_value   last value written to TOHOST_ADDRESS
//   protocol_error sticky flag, set when a request arrives while busy
// ---------------------------------------------------------------------------
module rvx_wait_state_responder #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0000_2000,
  parameter int          DEPTH_WORDS    = 256,
  parameter logic [31:0] TOHOST_ADDRESS = 32'h0000_1000,
  parameter int          WAIT_STATES    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] address,
  output logic [31:0] rdata,
  input  logic        rrequest,
  output logic        rresponse,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrobe,
  input  logic        wrequest,
  output logic        wresponse,
  output logic        tohost_valid,
  output logic [31:0] tohost_value,
  output logic        protocol_error
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES  = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS         = 4'(WAIT_STATES);
  localparam logic [31:0] TOHOST_WORD = TOHOST_ADDRESS & ~32'h3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic [31:0] r_address;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrobe;
  logic        r_isRead;
  logic        r_isWrite;
  logic        r_rresponse;
  logic        r_wresponse;
  logic [31:0] r_rdata;
  logic        r_tohostValid;
  logic [31:0] r_tohostValue;
  logic        r_protocolError;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_idle;
  logic          w_accept;
  logic          w_enterRespond;
  logic [31:0]   w_curAddress;
  logic [31:0]   w_curWdata;
  logic [3:0]    w_curStrobe;
  logic          w_curRead;
  logic          w_curWrite;
  logic [31:0]   w_wordAddress;
  logic [31:0]   w_offset;
  logic          w_ramHit;
  logic          w_tohostHit;
  logic [AW-1:0] w_index;
  logic [31:0]   w_ramWord;
  logic [31:0]   w_ramMerged;
  logic [31:0]   w_tohostMerged;
  logic [31:0]   w_readData;

  // Replace only the strobed bytes of oldWord with those of newWord.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  strobe);
    logic [31:0] result;
    result = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (strobe[b]) result[8*b +: 8] = newWord[8*b +: 8];
    end
    return result;
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && (rrequest || wrequest);

  // With zero wait states the access is performed on the same edge that
  // accepts the request, so the live bus inputs are used instead of the
  // latched copies while idle.
  assign w_curAddress = w_idle ? address  : r_address;
  assign w_curWdata   = w_idle ? wdata    : r_wdata;
  assign w_curStrobe  = w_idle ? wstrobe  : r_wstrobe;
  assign w_curRead    = w_idle ? rrequest : r_isRead;
  assign w_curWrite   = w_idle ? wrequest : r_isWrite;

  // The edge that moves the FSM into RESPOND is where the access happens,
  // so the registered responses and tohost update are visible in that cycle.
  assign w_enterRespond = (w_accept && (WS == 4'd0)) ||
                          ((r_state == S_WAIT) && (r_count == 4'd1));

  // An address below the base wraps to a huge offset, so the second
  // compare alone would suffice; the first keeps the intent obvious.
  assign w_wordAddress = w_curAddress & ~32'h3;
  assign w_offset      = w_wordAddress - BASE_ADDRESS;
  assign w_ramHit      = (w_wordAddress >= BASE_ADDRESS) && (w_offset < RAM_BYTES);
  assign w_tohostHit   = (w_wordAddress == TOHOST_WORD);
  assign w_index       = w_offset[AW+1:2];

  assign w_ramWord      = r_mem[w_index];
  assign w_ramMerged    = mergeBytes(w_ramWord, w_curWdata, w_curStrobe);
  assign w_tohostMerged = mergeBytes(r_tohostValue, w_curWdata, w_curStrobe);
  assign w_readData     = w_ramHit    ? w_ramWord     :
                          w_tohostHit ? r_tohostValue : 32'h0;

  // RAM storage has no reset; writes are taken on the RESPOND-entry edge.
  always_ff @(posedge clock) begin
    if (w_enterRespond && w_curWrite && w_ramHit) begin
      r_mem[w_index] <= w_ramMerged;
    end
  end

  // Request FSM with registered responses, read data and tohost register.
  // Reads sample the RAM on the same edge as the write, so a combined
  // read+write returns the pre-write contents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_count         <= 4'd0;
      r_address       <= 32'h0;
      r_wdata         <= 32'h0;
      r_wstrobe       <= 4'h0;
      r_isRead        <= 1'b0;
      r_isWrite       <= 1'b0;
      r_rresponse     <= 1'b0;
      r_wresponse     <= 1'b0;
      r_rdata         <= 32'h0;
      r_tohostValid   <= 1'b0;
      r_tohostValue   <= 32'h0;
      r_protocolError <= 1'b0;
    end else begin
      r_rresponse <= 1'b0;
      r_wresponse <= 1'b0;
      r_rdata     <= 32'h0;

      if (!w_idle && (rrequest || wrequest)) begin
        r_protocolError <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_address <= address;
            r_wdata   <= wdata;
            r_wstrobe <= wstrobe;
            r_isRead  <= rrequest;
            r_isWrite <= wrequest;
            r_count   <= WS;
            r_state   <= (WS == 4'd0) ? S_RESPOND : S_WAIT;
          end
        end
        S_WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) r_state <= S_RESPOND;
        end
        S_RESPOND: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_enterRespond) begin
        r_rresponse <= w_curRead;
        r_wresponse <= w_curWrite;
        if (w_curRead) r_rdata <= w_readData;
        if (w_curWrite && w_tohostHit) begin
          r_tohostValue <= w_tohostMerged;
          r_tohostValid <= 1'b1;
        end
      end
    end
  end

  assign rdata          = r_rdata;
  assign rresponse      = r_rresponse;
  assign wresponse      = r_wresponse;
  assign tohost_valid   = r_tohostValid;
  assign tohost_value   = r_tohostValue;
  assign protocol_error = r_protocolError;

endmodule

// File: tb/tb_rvx_wait_state_responder.sv
// ---------------------------------------------------------------------------
// tb_rvx_wait_state_responder
//
// Directed bench for rvx_wait_state_responder. Instance "dut" uses two wait
// states, instance "dutZero" uses zero wait states; both share clock and
// reset. Inputs change 1 time unit after a rising edge and outputs are
// observed at that same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_rvx_wait_state_responder;

  localparam logic [31:0] BASE   = 32'h0000_2000;
  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int          DEPTH  = 256;

  logic        clock;
  logic        reset_n;

  logic [31:0] address, wdata, rdata;
  logic [3:0]  wstrobe;
  logic        rrequest, wrequest, rresponse, wresponse;
  logic        tohostValid, protocolError;
  logic [31:0] tohostValue;

  logic [31:0] zAddress, zWdata, zRdata;
  logic [3:0]  zWstrobe;
  logic        zRrequest, zWrequest, zRresponse, zWresponse;
  logic        zTohostValid, zProtocolError;
  logic [31:0] zTohostValue;

  int compared;
  int mismatched;

  rvx_wait_state_responder #(
    .BASE_ADDRESS(BASE), .DEPTH_WORDS(DEPTH),
    .TOHOST_ADDRESS(TOHOST), .WAIT_STATES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .rdata(rdata),
    .rrequest(rrequest), .rresponse(rresponse), .wdata(wdata),
    .wstrobe(wstrobe), .wrequest(wrequest), .wresponse(wresponse),
    .tohost_valid(tohostValid), .tohost_value(tohostValue),
    .protocol_error(protocolError)
  );

  rvx_wait_state_responder #(
    .BASE_ADDRESS(BASE), .DEPTH_WORDS(DEPTH),
    .TOHOST_ADDRESS(TOHOST), .WAIT_STATES(0)
  ) dutZero (
    .clock(clock), .reset_n(reset_n), .address(zAddress), .rdata(zRdata),
    .rrequest(zRrequest), .rresponse(zRresponse), .wdata(zWdata),
    .wstrobe(zWstrobe), .wrequest(zWrequest), .wresponse(zWresponse),
    .tohost_valid(zTohostValid), .tohost_value(zTohostValue),
    .protocol_error(zProtocolError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Issue one request (read, write or both) on the chosen instance in the
  // current cycle and watch the following 8 cycles. Reports the cycle
  // offset of the first response of each kind, the number of responses,
  // the read data captured with rresponse, the tohost outputs at the
  // write response, and whether rdata was non-zero outside rresponse.
  task automatic applyStimulus(input bit useZero, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] strb,
                               output int rCyc, output int wCyc,
                               output int rCnt, output int wCnt,
                               output logic [31:0] rData,
                               output logic tvAtResp, output logic [31:0] tvalAtResp,
                               output bit leak);
    logic rr, wr2, tv;
    logic [31:0] rdv, tval;
    rCyc = -1; wCyc = -1; rCnt = 0; wCnt = 0; rData = 32'hx;
    tvAtResp = 1'bx; tvalAtResp = 32'hx; leak = 0;
    if (useZero) begin
      zAddress = addr; zWdata = wd; zWstrobe = strb; zRrequest = rd; zWrequest = wr;
    end else begin
      address = addr; wdata = wd; wstrobe = strb; rrequest = rd; wrequest = wr;
    end
    for (int k = 1; k <= 8; k++) begin
      nextCycle();
      if (k == 1) begin
        rrequest = 0; wrequest = 0; zRrequest = 0; zWrequest = 0;
      end
      rr   = useZero ? zRresponse   : rresponse;
      wr2  = useZero ? zWresponse   : wresponse;
      rdv  = useZero ? zRdata       : rdata;
      tv   = useZero ? zTohostValid : tohostValid;
      tval = useZero ? zTohostValue : tohostValue;
      if (rr) begin
        rCnt++;
        if (rCyc < 0) begin rCyc = k; rData = rdv; end
      end else if (rdv !== 32'h0) begin
        leak = 1;
      end
      if (wr2) begin
        wCnt++;
        if (wCyc < 0) begin wCyc = k; tvAtResp = tv; tvalAtResp = tval; end
      end
    end
  endtask

  int rC, wC, rN, wN;
  logic [31:0] rD, tval;
  logic tv;
  bit leak;

  task automatic test_reset();
    reset_n = 0;
    address = 0; wdata = 0; wstrobe = 0; rrequest = 0; wrequest = 0;
    zAddress = 0; zWdata = 0; zWstrobe = 0; zRrequest = 0; zWrequest = 0;
    repeat (3) nextCycle();
    compared++;
    if ({rresponse, wresponse, tohostValid, protocolError} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags got=%b want=0000",
               {rresponse, wresponse, tohostValid, protocolError});
    end
    compared++;
    if (rdata !== 32'h0 || tohostValue !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_data rdata=%h tohost=%h want 0/0", rdata, tohostValue);
    end
    reset_n = 1;
    nextCycle();
  endtask

  task automatic test_write_read();
    applyStimulus(0, 0, 1, BASE + 8, 32'hCAFEF00D, 4'hF, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (wC !== 3 || wN !== 1 || rN !== 0) begin
      mismatched++;
      $display("[TB] FAIL write_latency wCyc=%0d wCnt=%0d rCnt=%0d want 3/1/0", wC, wN, rN);
    end
    applyStimulus(0, 1, 0, BASE + 8, 32'h0, 4'h0, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (rC !== 3 || rN !== 1 || wN !== 0) begin
      mismatched++;
      $display("[TB] FAIL read_latency rCyc=%0d rCnt=%0d wCnt=%0d want 3/1/0", rC, rN, wN);
    end
    compared++;
    if (rD !== 32'hCAFEF00D) begin
      mismatched++;
      $display("[TB] FAIL read_data got=%h want=cafef00d", rD);
    end
    compared++;
    if (leak !== 0) begin
      mismatched++;
      $display("[TB] FAIL rdata_idle got=%0d want=0", leak);
    end
  endtask

  task automatic test_byte_strobes();
    applyStimulus(0, 0, 1, BASE + 12, 32'h11223344, 4'hF, rC, wC, rN, wN, rD, tv, tval, leak);
    applyStimulus(0, 0, 1, BASE + 12, 32'hAABBCCDD, 4'b0101, rC, wC, rN, wN, rD, tv, tval, leak);
    applyStimulus(0, 1, 0, BASE + 12, 32'h0, 4'h0, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (rD !== 32'h11BB33DD) begin
      mismatched++;
      $display("[TB] FAIL byte_strobe got=%h want=11bb33dd", rD);
    end
    applyStimulus(0, 0, 1, BASE + 12, 32'hFFFFFFFF, 4'h0, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (wC !== 3) begin
      mismatched++;
      $display("[TB] FAIL zero_strobe_resp wCyc=%0d want=3", wC);
    end
    applyStimulus(0, 1, 0, BASE + 12, 32'h0, 4'h0, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (rD !== 32'h11BB33DD) begin
      mismatched++;
      $display("[TB] FAIL zero_strobe_data got=%h want=11bb33dd", rD);
    end
  endtask

  task automatic test_tohost();
    applyStimulus(0, 0, 1, TOHOST, 32'h00000001, 4'hF, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (wC !== 3 || tv !== 1'b1 || tval !== 32'h1) begin
      mismatched++;
      $display("[TB] FAIL tohost_resp wCyc=%0d valid=%b value=%h want 3/1/00000001", wC, tv, tval);
    end
    repeat (100) nextCycle();
    compared++;
    if (tohostValid !== 1'b1 || tohostValue !== 32'h1) begin
      mismatched++;
      $display("[TB] FAIL tohost_hold valid=%b value=%h want 1/00000001", tohostValid, tohostValue);
    end
    applyStimulus(0, 1, 0, TOHOST + 2, 32'h0, 4'h0, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (rD !== 32'h1) begin
      mismatched++;
      $display("[TB] FAIL tohost_read got=%h want=00000001", rD);
    end
  endtask

  task automatic test_out_of_range();
    applyStimulus(0, 0, 1, BASE, 32'h12345678, 4'hF, rC, wC, rN, wN, rD, tv, tval, leak);
    applyStimulus(0, 1, 0, BASE + 4 * DEPTH, 32'h0, 4'h0, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (rC !== 3 || rD !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL oor_read rCyc=%0d data=%h want 3/00000000", rC, rD);
    end
    applyStimulus(0, 0, 1, BASE + 4 * DEPTH, 32'hDEADBEEF, 4'hF, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (wC !== 3) begin
      mismatched++;
      $display("[TB] FAIL oor_write_resp wCyc=%0d want=3", wC);
    end
    applyStimulus(0, 1, 0, BASE, 32'h0, 4'h0, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (rD !== 32'h12345678) begin
      mismatched++;
      $display("[TB] FAIL oor_no_alias got=%h want=12345678", rD);
    end
  endtask

  task automatic test_back_to_back();
    int rCount, wCount;
    applyStimulus(0, 0, 1, BASE + 16, 32'h00000077, 4'hF, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (protocolError !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL perr_before got=%b want=0", protocolError);
    end
    rCount = 0; wCount = 0;
    address = BASE + 16; rrequest = 1;
    nextCycle();
    rrequest = 0; wrequest = 1; wdata = 32'h000000FF; wstrobe = 4'hF;
    nextCycle();
    wrequest = 0;
    compared++;
    if (protocolError !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL perr_set got=%b want=1", protocolError);
    end
    if (rresponse) rCount++;
    if (wresponse) wCount++;
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      if (rresponse) rCount++;
      if (wresponse) wCount++;
    end
    compared++;
    if (rCount !== 1 || wCount !== 0) begin
      mismatched++;
      $display("[TB] FAIL busy_responses rCnt=%0d wCnt=%0d want 1/0", rCount, wCount);
    end
    applyStimulus(0, 1, 0, BASE + 16, 32'h0, 4'h0, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (rD !== 32'h77 || protocolError !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL busy_write_dropped data=%h perr=%b want 00000077/1", rD, protocolError);
    end
    applyStimulus(0, 0, 1, BASE + 20, 32'h5, 4'hF, rC, wC, rN, wN, rD, tv, tval, leak);
    applyStimulus(0, 1, 1, BASE + 20, 32'h9, 4'hF, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (rC !== 3 || wC !== 3 || rD !== 32'h5) begin
      mismatched++;
      $display("[TB] FAIL combined rCyc=%0d wCyc=%0d data=%h want 3/3/00000005", rC, wC, rD);
    end
    applyStimulus(0, 1, 0, BASE + 20, 32'h0, 4'h0, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (rD !== 32'h9) begin
      mismatched++;
      $display("[TB] FAIL combined_after got=%h want=00000009", rD);
    end
  endtask

  task automatic test_reset_mid_wait();
    int wCount;
    applyStimulus(0, 0, 1, BASE + 24, 32'h42, 4'hF, rC, wC, rN, wN, rD, tv, tval, leak);
    wCount = 0;
    address = BASE + 24; wdata = 32'hBADBAD00; wstrobe = 4'hF; wrequest = 1;
    nextCycle();
    wrequest = 0;
    reset_n = 0;
    #1;
    compared++;
    if ({rresponse, wresponse, tohostValid, protocolError} !== 4'b0 ||
        rdata !== 32'h0 || tohostValue !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_outputs flags=%b rdata=%h tohost=%h want 0000/0/0",
               {rresponse, wresponse, tohostValid, protocolError}, rdata, tohostValue);
    end
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      if (wresponse) wCount++;
    end
    reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      if (wresponse) wCount++;
    end
    compared++;
    if (wCount !== 0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_noresp wCnt=%0d want=0", wCount);
    end
    applyStimulus(0, 1, 0, BASE + 24, 32'h0, 4'h0, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (rD !== 32'h42) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_lost got=%h want=00000042", rD);
    end
  endtask

  task automatic test_zero_wait();
    applyStimulus(1, 0, 1, BASE + 4, 32'h00000ABC, 4'hF, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (wC !== 1 || wN !== 1) begin
      mismatched++;
      $display("[TB] FAIL zero_wait_write wCyc=%0d wCnt=%0d want 1/1", wC, wN);
    end
    applyStimulus(1, 1, 0, BASE + 4, 32'h0, 4'h0, rC, wC, rN, wN, rD, tv, tval, leak);
    compared++;
    if (rC !== 1 || rD !== 32'h00000ABC || leak !== 0) begin
      mismatched++;
      $display("[TB] FAIL zero_wait_read rCyc=%0d data=%h leak=%0d want 1/00000abc/0", rC, rD, leak);
    end
  endtask

  // Scenarios run in order; later ones rely on the reset done by the first.
  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_write_read();
    test_byte_strobes();
    test_tohost();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_wait();
    test_zero_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
